// File: rtl/uart_rx.sv
// Oversampled UART receiver: start-bit validation at mid-bit, centre sampling of
// data bits, valid/ready byte output with framing and overrun error pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clock_edge,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    logic w_half;
    logic w_full;
    logic w_last_bit;
    logic w_stop_sample;
    logic w_deliver;
    logic w_frame_bad;

    assign w_half     = (r_tick_cnt == HALF_LAST);
    assign w_full     = (r_tick_cnt == BIT_LAST);
    assign w_last_bit = (r_bit_cnt == DATA_LAST);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clock_edge) begin
            case (r_state)
                S_IDLE:  if (!r_rx_s) w_state_next = S_START;
                S_START: if (w_half) w_state_next = r_rx_s ? S_IDLE : S_DATA;
                S_DATA:  if (w_full && w_last_bit) w_state_next = S_STOP;
                S_STOP:  if (w_full) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (r_rx_s) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stop_sample = clock_edge && (r_state == S_STOP) && w_full;
        w_deliver     = w_stop_sample && r_rx_s;
        w_frame_bad   = w_stop_sample && !r_rx_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (clock_edge) begin
            case (r_state)
                S_START: begin
                    r_tick_cnt <= w_half ? '0 : r_tick_cnt + 1'b1;
                    r_bit_cnt  <= '0;
                end
                S_DATA: begin
                    if (w_full) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tick_cnt <= w_full ? '0 : r_tick_cnt + 1'b1;
                end
                default: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

    // A delivery while the consumer is taking the old byte reloads without a gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            framing_error <= w_frame_bad;
            overrun_error <= w_deliver && data_valid && !data_ready;
            if (w_deliver) begin
                if (!data_valid || data_ready) begin
                    data       <= r_shift;
                    data_valid <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16, DATA_BITS=8, tick every 4 clk (64 clk/bit).
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       clock_edge;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] ce_div;
    int fe_cnt = 0;
    int oe_cnt = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int hi_cnt = 0;
    logic [7:0] rise_data = 8'h00;
    logic prev_valid = 1'b0;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clock_edge   (clock_edge),
        .rx           (rx),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick is high for the posedge following a negedge at which ce_div==0.
    initial begin
        clock_edge = 1'b0;
        ce_div = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            ce_div = ce_div + 2'd1;
            clock_edge = (ce_div == 2'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (framing_error) fe_cnt++;
            if (overrun_error) oe_cnt++;
            if (data_valid) hi_cnt++;
            if (data_valid && !prev_valid) begin
                rise_cnt++;
                rise_data = data;
            end
            if (!data_valid && prev_valid) fall_cnt++;
            prev_valid = data_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the bench at the negedge before P0 such that the DUT's first tick
    // seeing the synchronised start bit is P0+2; stop is sampled at P0+610.
    task automatic align_tick();
        do @(negedge clk); while (ce_div != 2'd2);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        rx = stop;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        align_tick();
        send_bits(b, 1'b1);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data, data_valid, framing_error, overrun_error} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got data=%h v=%b fe=%b oe=%b expected all 0",
                     data, data_valid, framing_error, overrun_error);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({data, data_valid, framing_error, overrun_error} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_release: got data=%h v=%b fe=%b oe=%b expected all 0",
                     data, data_valid, framing_error, overrun_error);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int fe0, oe0, r0, h0;
        fe0 = fe_cnt; oe0 = oe_cnt; r0 = rise_cnt; h0 = hi_cnt;
        data_ready = 1'b1;
        send_frame(8'h55);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (hi_cnt - h0 !== 1) begin
            n_bad++;
            $display("FAIL t1_valid_cycles: got %0d expected 1", hi_cnt - h0);
        end
        n_cmp++;
        if (rise_data !== 8'h55 || rise_cnt - r0 !== 1) begin
            n_bad++;
            $display("FAIL t1_data: got %h (rises %0d) expected 55 (rises 1)", rise_data, rise_cnt - r0);
        end
        n_cmp++;
        if (fe_cnt - fe0 !== 0 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL t1_errors: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0);
        end
        $display("test_basic frame 55 data=%h", rise_data);
    endtask

    task automatic test_glitch();
        int fe0, oe0, r0;
        fe0 = fe_cnt; oe0 = oe_cnt; r0 = rise_cnt;
        align_tick();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        n_cmp++;
        if (rise_cnt - r0 !== 0 || fe_cnt - fe0 !== 0 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL t2_glitch: got rises=%0d fe=%0d oe=%0d expected 0 0 0",
                     rise_cnt - r0, fe_cnt - fe0, oe_cnt - oe0);
        end
        send_frame(8'h3C);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (rise_cnt - r0 !== 1 || rise_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL t2_recover: got rises=%0d data=%h expected 1 3c", rise_cnt - r0, rise_data);
        end
        $display("test_glitch follow-up data=%h", rise_data);
    endtask

    task automatic test_framing();
        int fe0, oe0, r0;
        fe0 = fe_cnt; oe0 = oe_cnt; r0 = rise_cnt;
        data_ready = 1'b1;
        align_tick();
        send_bits(8'hA3, 1'b0);
        repeat (192) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        n_cmp++;
        if (fe_cnt - fe0 !== 1 || rise_cnt - r0 !== 0) begin
            n_bad++;
            $display("FAIL t3_framing: got fe=%0d rises=%0d expected 1 0", fe_cnt - fe0, rise_cnt - r0);
        end
        send_frame(8'h0F);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (rise_cnt - r0 !== 1 || rise_data !== 8'h0F) begin
            n_bad++;
            $display("FAIL t3_after_break: got rises=%0d data=%h expected 1 0f", rise_cnt - r0, rise_data);
        end
        n_cmp++;
        if (fe_cnt - fe0 !== 1 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL t3_errors: got fe=%0d oe=%0d expected 1 0", fe_cnt - fe0, oe_cnt - oe0);
        end
        $display("test_framing fe=%0d data=%h", fe_cnt - fe0, rise_data);
    endtask

    task automatic test_overrun();
        int fe0, oe0;
        fe0 = fe_cnt; oe0 = oe_cnt;
        data_ready = 1'b0;
        send_frame(8'h11);
        send_frame(8'h22);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (data !== 8'h11 || data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL t4_hold: got data=%h v=%b expected 11 1", data, data_valid);
        end
        n_cmp++;
        if (oe_cnt - oe0 !== 1 || fe_cnt - fe0 !== 0) begin
            n_bad++;
            $display("FAIL t4_overrun: got oe=%0d fe=%0d expected 1 0", oe_cnt - oe0, fe_cnt - fe0);
        end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        n_cmp++;
        if (data_valid !== 1'b0 || data !== 8'h11) begin
            n_bad++;
            $display("FAIL t4_accept: got v=%b data=%h expected 0 11", data_valid, data);
        end
        $display("test_overrun oe=%0d data=%h", oe_cnt - oe0, data);
    endtask

    task automatic test_back_to_back();
        int oe0, f0;
        data_ready = 1'b0;
        send_frame(8'h11);
        repeat (8) @(negedge clk);
        oe0 = oe_cnt; f0 = fall_cnt;
        align_tick();
        fork
            send_bits(8'h22, 1'b1);
            begin
                repeat (610) @(negedge clk);
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (data !== 8'h22 || data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL t5_reload: got data=%h v=%b expected 22 1", data, data_valid);
        end
        n_cmp++;
        if (oe_cnt - oe0 !== 0 || fall_cnt - f0 !== 0) begin
            n_bad++;
            $display("FAIL t5_no_gap: got oe=%0d falls=%0d expected 0 0", oe_cnt - oe0, fall_cnt - f0);
        end
        $display("test_back_to_back data=%h valid=%b", data, data_valid);
    endtask

    task automatic test_async_reset();
        int fe0, oe0, r0;
        data_ready = 1'b0;
        align_tick();
        fork
            send_bits(8'hC6, 1'b1);
            begin
                repeat (280) @(negedge clk);
                reset_n = 1'b0;
                #1;
                n_cmp++;
                if ({data, data_valid, framing_error, overrun_error} !== 11'd0) begin
                    n_bad++;
                    $display("FAIL t6_async: got data=%h v=%b fe=%b oe=%b expected all 0",
                             data, data_valid, framing_error, overrun_error);
                end
            end
        join
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (64) @(negedge clk);
        fe0 = fe_cnt; oe0 = oe_cnt; r0 = rise_cnt;
        data_ready = 1'b1;
        send_frame(8'hC6);
        repeat (16) @(negedge clk);
        n_cmp++;
        if (rise_cnt - r0 !== 1 || rise_data !== 8'hC6) begin
            n_bad++;
            $display("FAIL t6_after: got rises=%0d data=%h expected 1 c6", rise_cnt - r0, rise_data);
        end
        n_cmp++;
        if (fe_cnt - fe0 !== 0 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL t6_errors: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0);
        end
        $display("test_async_reset data=%h", rise_data);
    endtask

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        data_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
